// File: rtl/serial_boot_loader.sv
// Serial boot loader: deserialises framed 32-bit words from sclk/sdata, validates
// header, count and checksum, writes payload to IRAM and releases the core on success.
module serial_boot_loader #(
    parameter int          ADDR_W      = 7,
    parameter int          DEPTH       = 128,
    parameter logic [15:0] MAGIC       = 16'hB007,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              sclk,
    input  logic              sdata,
    output logic [ADDR_W-1:0] iram_addr,
    output logic [31:0]       iram_wdata,
    output logic              iram_wen,
    output logic              core_ready,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code,
    output logic [ADDR_W:0]   words_loaded
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HEADER = 3'd1,
        ST_DATA   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    state_t state_r, state_s;

    logic [SYNC_STAGES-1:0] sclk_sync_r, sdata_sync_r;
    logic                   sclk_prev_r, rise_r, bit_r, load_en_d_r;

    logic [4:0]        bit_cnt_r, bit_cnt_s;
    logic [31:0]       shift_r, shift_s;
    logic [31:0]       checksum_r, checksum_s;
    logic [ADDR_W:0]   count_r, count_s;
    logic [ADDR_W:0]   wl_r, wl_s;
    logic [ADDR_W-1:0] iram_addr_r, addr_s;
    logic [31:0]       iram_wdata_r, wdata_s;
    logic              iram_wen_r, wen_s;
    logic              core_ready_r, core_ready_s;
    logic              load_done_r, done_s;
    logic              load_err_r, err_s;
    logic [1:0]        err_code_r, code_s;

    logic [31:0]     word_s;
    logic            word_done_s, active_s, abort_s, start_s, hdr_bad_s;
    logic [ADDR_W:0] wl_inc_s;

    // Pin synchronisers plus one edge/data register stage of equal depth
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_r  <= {SYNC_STAGES{1'b0}};
            sdata_sync_r <= {SYNC_STAGES{1'b0}};
            sclk_prev_r  <= 1'b0;
            rise_r       <= 1'b0;
            bit_r        <= 1'b0;
            load_en_d_r  <= 1'b0;
        end else begin
            sclk_sync_r  <= {sclk_sync_r[SYNC_STAGES-2:0], sclk};
            sdata_sync_r <= {sdata_sync_r[SYNC_STAGES-2:0], sdata};
            sclk_prev_r  <= sclk_sync_r[SYNC_STAGES-1];
            rise_r       <= sclk_sync_r[SYNC_STAGES-1] & ~sclk_prev_r;
            bit_r        <= sdata_sync_r[SYNC_STAGES-1];
            load_en_d_r  <= load_en;
        end
    end

    assign word_s      = {bit_r, shift_r[31:1]};
    assign word_done_s = rise_r & (bit_cnt_r == 5'd31);
    assign active_s    = (state_r == ST_HEADER) || (state_r == ST_DATA) || (state_r == ST_CHECK);
    assign abort_s     = active_s & ~load_en;
    assign hdr_bad_s   = (word_s[31:16] != MAGIC) || (word_s[15:0] == 16'd0) ||
                         (word_s[15:0] > 16'(DEPTH));
    assign wl_inc_s    = wl_r + {{ADDR_W{1'b0}}, 1'b1};
    // Leaving DONE/ERROR needs a fresh load_en rise; IDLE only needs the level
    assign start_s     = ((state_r == ST_IDLE) && load_en) ||
                         (((state_r == ST_DONE) || (state_r == ST_ERROR)) && load_en && !load_en_d_r);

    // Next-state and next-output logic
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        checksum_s   = checksum_r;
        count_s      = count_r;
        wl_s         = wl_r;
        addr_s       = {ADDR_W{1'b0}};
        wdata_s      = iram_wdata_r;
        wen_s        = 1'b0;
        core_ready_s = core_ready_r;
        done_s       = load_done_r;
        err_s        = load_err_r;
        code_s       = err_code_r;

        if (active_s && load_en && rise_r) begin
            shift_s   = word_s;
            bit_cnt_s = bit_cnt_r + 5'd1;
        end else if (active_s && load_en) begin
            bit_cnt_s = bit_cnt_r;
        end else begin
            bit_cnt_s = 5'd0;
        end

        if (start_s) begin
            state_s      = ST_HEADER;
            bit_cnt_s    = 5'd0;
            shift_s      = 32'd0;
            checksum_s   = 32'd0;
            count_s      = {(ADDR_W+1){1'b0}};
            wl_s         = {(ADDR_W+1){1'b0}};
            core_ready_s = 1'b0;
            done_s       = 1'b0;
            err_s        = 1'b0;
            code_s       = 2'd0;
        end else if (abort_s) begin
            state_s = ST_ERROR;
            err_s   = 1'b1;
            code_s  = 2'd3;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    core_ready_s = 1'b0;
                end
                ST_HEADER: begin
                    if (word_done_s && hdr_bad_s) begin
                        state_s = ST_ERROR;
                        err_s   = 1'b1;
                        code_s  = 2'd1;
                    end else if (word_done_s) begin
                        count_s = word_s[ADDR_W:0];
                        state_s = ST_DATA;
                    end else begin
                        state_s = ST_HEADER;
                    end
                end
                ST_DATA: begin
                    if (word_done_s) begin
                        wen_s      = 1'b1;
                        addr_s     = wl_r[ADDR_W-1:0];
                        wdata_s    = word_s;
                        checksum_s = checksum_r + word_s;
                        wl_s       = wl_inc_s;
                        state_s    = (wl_inc_s == count_r) ? ST_CHECK : ST_DATA;
                    end else begin
                        state_s = ST_DATA;
                    end
                end
                ST_CHECK: begin
                    if (word_done_s && (word_s == checksum_r)) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                    end else if (word_done_s) begin
                        state_s = ST_ERROR;
                        err_s   = 1'b1;
                        code_s  = 2'd2;
                    end else begin
                        state_s = ST_CHECK;
                    end
                end
                ST_DONE: begin
                    core_ready_s = ~load_en;
                end
                ST_ERROR: begin
                    core_ready_s = 1'b0;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_r    <= 5'd0;
            shift_r      <= 32'd0;
            checksum_r   <= 32'd0;
            count_r      <= {(ADDR_W+1){1'b0}};
            wl_r         <= {(ADDR_W+1){1'b0}};
            iram_addr_r  <= {ADDR_W{1'b0}};
            iram_wdata_r <= 32'd0;
            iram_wen_r   <= 1'b0;
            core_ready_r <= 1'b0;
            load_done_r  <= 1'b0;
            load_err_r   <= 1'b0;
            err_code_r   <= 2'd0;
        end else begin
            bit_cnt_r    <= bit_cnt_s;
            shift_r      <= shift_s;
            checksum_r   <= checksum_s;
            count_r      <= count_s;
            wl_r         <= wl_s;
            iram_addr_r  <= addr_s;
            iram_wdata_r <= wdata_s;
            iram_wen_r   <= wen_s;
            core_ready_r <= core_ready_s;
            load_done_r  <= done_s;
            load_err_r   <= err_s;
            err_code_r   <= code_s;
        end
    end

    assign iram_addr    = iram_addr_r;
    assign iram_wdata   = iram_wdata_r;
    assign iram_wen     = iram_wen_r;
    assign core_ready   = core_ready_r;
    assign load_done    = load_done_r;
    assign load_err     = load_err_r;
    assign err_code     = err_code_r;
    assign words_loaded = wl_r;

endmodule

// File: tb/tb_serial_boot_loader.sv
// Bench for serial_boot_loader: directed and random frames compared against a
// frame-level reference model of the expected IRAM writes and status.
module tb_serial_boot_loader;

    logic        clk = 1'b0;
    logic        rst, load_en, sclk, sdata;
    logic [6:0]  iram_addr;
    logic [31:0] iram_wdata;
    logic        iram_wen, core_ready, load_done, load_err;
    logic [1:0]  err_code;
    logic [7:0]  words_loaded;

    int n_vec = 0;
    int n_err = 0;
    int idle_addr_bad = 0;

    logic [31:0] stream_q[$];
    int          abort_at;
    logic [38:0] got_q[$];
    logic [38:0] exp_q[$];
    logic        exp_done, exp_err;
    logic [1:0]  exp_code;
    int          exp_wl;

    serial_boot_loader dut (
        .clk(clk), .rst(rst), .load_en(load_en), .sclk(sclk), .sdata(sdata),
        .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_wen(iram_wen),
        .core_ready(core_ready), .load_done(load_done), .load_err(load_err),
        .err_code(err_code), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    // Collect IRAM writes; address must rest at 0 between writes
    always @(negedge clk) begin
        if (iram_wen) got_q.push_back({iram_addr, iram_wdata});
        else if (iram_addr != 7'd0) idle_addr_bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bits(input int nb);
        for (int b = 0; b < nb; b++) begin
            logic [31:0] w;
            w = stream_q[b / 32];
            sdata = w[b % 32];
            #30 sclk = 1'b1;
            #30 sclk = 1'b0;
        end
    endtask

    task automatic build_valid(input int n, input logic [31:0] corrupt);
        logic [31:0] sum;
        stream_q.delete();
        stream_q.push_back({16'hB007, 16'(n)});
        sum = 32'd0;
        for (int i = 0; i < n; i++) begin
            stream_q.push_back($urandom);
            sum += stream_q[i + 1];
        end
        stream_q.push_back(sum ^ corrupt);
    endtask

    // Frame-level reference: what a loader must do with the bits actually sent
    task automatic model();
        int nb, n;
        logic [31:0] sum, hdr;
        exp_q.delete();
        exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'd0; exp_wl = 0;
        nb = (abort_at < 0) ? 32 * stream_q.size() : abort_at;
        if (nb < 32) begin
            exp_err = 1'b1; exp_code = 2'd3;
        end else begin
            hdr = stream_q[0];
            n = int'(hdr[15:0]);
            if (hdr[31:16] != 16'hB007 || n == 0 || n > 128) begin
                exp_err = 1'b1; exp_code = 2'd1;
            end else begin
                sum = 32'd0;
                for (int i = 0; i < n; i++) begin
                    if (nb >= 32 * (i + 2) && i + 1 < stream_q.size()) begin
                        exp_q.push_back({7'(i), stream_q[i + 1]});
                        sum += stream_q[i + 1];
                        exp_wl = i + 1;
                    end
                end
                if (exp_wl < n) begin
                    exp_err = 1'b1; exp_code = 2'd3;
                end else if (nb >= 32 * (n + 2) && stream_q.size() > n + 1) begin
                    if (stream_q[n + 1] == sum) exp_done = 1'b1;
                    else begin exp_err = 1'b1; exp_code = 2'd2; end
                end else begin
                    exp_err = 1'b1; exp_code = 2'd3;
                end
            end
        end
    endtask

    task automatic run_frame(input string tag);
        int nb;
        got_q.delete();
        @(negedge clk); load_en = 1'b1;
        @(negedge clk); check({tag, ".rdy_start"}, core_ready, 0);
        repeat (2) @(negedge clk);
        nb = (abort_at < 0) ? 32 * stream_q.size() : abort_at;
        send_bits(nb);
        if (abort_at >= 0) begin
            #10 load_en = 1'b0;
        end
        repeat (12) @(negedge clk);
        model();
        check({tag, ".done"}, load_done, exp_done);
        check({tag, ".err"}, load_err, exp_err);
        check({tag, ".code"}, err_code, exp_code);
        check({tag, ".wl"}, words_loaded, exp_wl);
        check({tag, ".nwr"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check({tag, ".wr"}, got_q[i], exp_q[i]);
        if (abort_at < 0) check({tag, ".rdy_held"}, core_ready, 0);
        load_en = 1'b0;
        @(negedge clk); check({tag, ".rdy_drop"}, core_ready, exp_done);
    endtask

    initial begin
        rst = 1'b1; load_en = 1'b0; sclk = 1'b0; sdata = 1'b0;
        repeat (3) @(negedge clk);
        check("reset", {iram_addr, iram_wdata, iram_wen, core_ready, load_done,
                        load_err, err_code, words_loaded}, 0);
        rst = 1'b0;

        stream_q = '{32'hB007_0003, 32'h11, 32'h22, 32'h33, 32'h66};
        abort_at = -1; run_frame("t1");
        stream_q = '{32'hB007_0002, 32'd5, 32'd6, 32'd12};
        abort_at = -1; run_frame("t2");
        stream_q = '{32'hBEEF_0001};
        abort_at = -1; run_frame("t3a");
        stream_q = '{32'hB007_0000};
        abort_at = -1; run_frame("t3b");
        stream_q = '{32'hB007_0081};
        abort_at = -1; run_frame("t3c");
        build_valid(3, 32'd0);
        abort_at = 32 * 2 + 17; run_frame("t4abort");
        abort_at = -1; run_frame("t4retry");
        build_valid(128, 32'd0);
        abort_at = -1; run_frame("t5full");

        for (int r = 0; r < 8; r++) begin
            int kind, n;
            kind = $urandom_range(0, 3);
            n = $urandom_range(1, 8);
            abort_at = -1;
            case (kind)
                0: build_valid(n, 32'd0);
                1: build_valid(n, 32'($urandom_range(1, 255)));
                2: begin
                    stream_q.delete();
                    case ($urandom_range(0, 2))
                        0: stream_q.push_back({16'hB007 ^ 16'($urandom_range(1, 65535)), 16'd1});
                        1: stream_q.push_back({16'hB007, 16'd0});
                        default: stream_q.push_back({16'hB007, 16'($urandom_range(129, 65535))});
                    endcase
                end
                default: begin
                    build_valid(n, 32'd0);
                    abort_at = $urandom_range(1, 32 * (n + 2) - 1);
                end
            endcase
            run_frame("rnd");
        end

        // Asynchronous reset in the middle of a long payload
        build_valid(128, 32'd0);
        got_q.delete();
        @(negedge clk); load_en = 1'b1;
        repeat (3) @(negedge clk);
        send_bits(32 * 10 + 5);
        rst = 1'b1; load_en = 1'b0;
        #1 check("rst_mid", {iram_addr, iram_wdata, iram_wen, core_ready, load_done,
                             load_err, err_code, words_loaded}, 0);
        check("rst_pre_writes", got_q.size(), 9);
        @(negedge clk); rst = 1'b0;
        build_valid(2, 32'd0);
        abort_at = -1; run_frame("post_rst");

        check("idle_addr", idle_addr_bad, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
